capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Acquisition controller for the scope front end.
- Takes the 14-bit signed sample stream from the ADC SPI front end, decimates it and runs it through a ring buffer.
- Detects a level/slope trigger, then sequences pre-trigger fill, trigger wait and post-trigger capture into the sample RAM.
- Hands the finished frame to the display/readout logic through a done/rd_done handshake.

Parameters:
- SAMPLE_W, 14, sample width (two's complement)
- ADDR_W, 10, sample RAM address width; DEPTH = 2**ADDR_W
- PRE_DEPTH, 256, samples retained before the trigger sample (must be < DEPTH)
- AUTO_TO, 2048, accepted samples in WAIT_TRIG before auto mode forces a trigger

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- sample_valid  in  1  one-cycle strobe, new ADC sample on sample_data
- sample_data  in  SAMPLE_W  signed ADC sample
- arm  in  1  pulse: start a capture (honoured in IDLE only)
- abort  in  1  pulse: return to IDLE from any state
- cont  in  1  1 = re-arm automatically after readout
- auto_mode  in  1  1 = force trigger after AUTO_TO samples
- trig_slope  in  1  0 = rising, 1 = falling
- trig_level  in  SAMPLE_W  signed trigger threshold
- decim  in  8  keep 1 of every decim+1 valid samples
- rd_done  in  1  pulse from readout: frame consumed
- wr_en  out  1  sample RAM write strobe
- wr_addr  out  ADDR_W  sample RAM write address
- wr_data  out  SAMPLE_W  sample RAM write data
- frame_start  out  ADDR_W  address of oldest sample of the frame
- done  out  1  frame complete, RAM contents stable
- forced  out  1  last frame was auto-triggered
- busy  out  1  state is not IDLE and not DONE

Behaviour:
- Reset values (rst=0): state IDLE; wr_en 0; wr_addr 0; wr_data 0; frame_start 0; done 0; forced 0; busy 0; all counters 0; prev_valid 0.
- Decimation:
  - dcnt counts sample_valid strobes in PRE/WAIT_TRIG/POST.
  - A sample is accepted when dcnt==0; dcnt then reloads to decim and decrements on each later strobe.
  - decim=0 accepts every sample. dcnt clears on entry to PRE.
  - decim changes take effect at the next reload.
- Writes:
  - An accepted sample produces wr_en=1 for exactly one cycle, on the cycle after sample_valid (1-cycle latency).
  - wr_data holds the sample; wr_addr holds the current pointer.
  - The pointer increments after each write and wraps DEPTH-1 -> 0.
  - No writes occur in IDLE or DONE.
- Trigger compare (signed, on accepted samples only, with prev = last accepted sample):
  - rising: prev < trig_level AND cur >= trig_level
  - falling: prev >= trig_level AND cur < trig_level
  - Requires prev_valid, which is set by the first accepted sample after entering PRE.
- FSM:
  - IDLE: arm -> PRE. Pointer and counters clear; forced clears.
  - PRE: count accepted samples. Trigger is not evaluated, but prev is updated. After PRE_DEPTH accepted samples -> WAIT_TRIG.
  - WAIT_TRIG: ring-buffer writes continue.
    - Trigger condition on an accepted sample: that sample is written as the trigger sample, trig_addr = its address, -> POST.
    - If auto_mode=1 and AUTO_TO accepted samples pass without a trigger: the next accepted sample is the trigger sample, forced=1.
  - POST: write DEPTH-PRE_DEPTH-1 further accepted samples, then -> DONE the cycle after the last write.
  - DONE: done=1; frame_start = trig_addr - PRE_DEPTH (mod DEPTH), registered on DONE entry.
    - rd_done -> IDLE if cont=0, or -> PRE if cont=1. done drops on the same edge.
- Boundary conditions:
  - abort has priority over every other input: next state IDLE, in-flight wr_en suppressed, done 0.
  - arm outside IDLE is ignored; rd_done outside DONE is ignored.
  - arm and abort asserted in the same cycle in IDLE: stay IDLE.
  - A trigger on the final sample of PRE is not detected; evaluation starts with the first WAIT_TRIG sample.
  - Frame (frame_start .. frame_start+DEPTH-1, wrapped) is contiguous and contains exactly DEPTH samples, trigger sample at offset PRE_DEPTH.
  - Asynchronous reset mid-capture returns all outputs to reset values immediately.

Test Plan:
1. decim=0, rising, level=100, ramp 0,1,2,… from arm -> 256 PRE writes; trigger at sample value 256 (first WAIT_TRIG sample >=100 with prev<100 never occurs). Use instead a ramp restarting at -200 after PRE -> trigger sample 100; done after 768 post writes (incl. trigger); frame_start = trig_addr-256 mod 1024.
2. Falling, level=0, sine ±4000, decim=3 -> exactly 1 write per 4 sample_valid; trigger sample is the first accepted value <0 after a value >=0; forced=0.
3. auto_mode=1, constant input 50, level=1000 -> forced trigger after 2048 accepted WAIT_TRIG samples; done=1, forced=1.
4. auto_mode=0, constant input -> stays WAIT_TRIG indefinitely, busy=1, done=0; abort -> IDLE next cycle, busy=0, no further wr_en.
5. cont=1: complete frame, pulse rd_done -> done=0 and PRE the next cycle; pointer restarts at 0; second frame completes normally. With cont=0 the same pulse -> IDLE.
6. Assert rst=0 during POST -> wr_en, done and busy all 0 without a clock edge; after release, arm starts a clean capture from address 0.

Source files
------------

// File: rtl/capture_if.sv
// Capture controller bus: ADC sample stream and control in, sample-RAM writes and frame status out.
// The master side drives samples and controls; the slave side (the controller) drives RAM writes and status.
interface capture_if #(
  parameter int SAMPLE_W = 14,
  parameter int ADDR_W   = 10
);
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample_data;
  logic                       arm;
  logic                       abort;
  logic                       cont;
  logic                       auto_mode;
  logic                       trig_slope;
  logic signed [SAMPLE_W-1:0] trig_level;
  logic [7:0]                 decim;
  logic                       rd_done;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic signed [SAMPLE_W-1:0] wr_data;
  logic [ADDR_W-1:0]          frame_start;
  logic                       done;
  logic                       forced;
  logic                       busy;

  modport master (
    output sample_valid, sample_data, arm, abort, cont, auto_mode,
           trig_slope, trig_level, decim, rd_done,
    input  wr_en, wr_addr, wr_data, frame_start, done, forced, busy
  );

  modport slave (
    input  sample_valid, sample_data, arm, abort, cont, auto_mode,
           trig_slope, trig_level, decim, rd_done,
    output wr_en, wr_addr, wr_data, frame_start, done, forced, busy
  );
endinterface

// File: rtl/capture_ctrl.sv
// Scope acquisition: decimate, ring-buffer into sample RAM, trigger, post-capture, hand off frame.
// RAM write lands one cycle after the accepted sample strobe; no backpressure, frame held until rd_done.
module capture_ctrl #(
  parameter int SAMPLE_W  = 14,
  parameter int ADDR_W    = 10,
  parameter int PRE_DEPTH = 256,
  parameter int AUTO_TO   = 2048
) (
  input logic      clk,
  input logic      rst,
  capture_if.slave cif
);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int POST_N = DEPTH - PRE_DEPTH - 1;
  localparam int PW     = $clog2(PRE_DEPTH + 1);
  localparam int AW     = $clog2(AUTO_TO + 1);

  localparam logic [PW-1:0]     PRE_LAST = PW'(PRE_DEPTH - 1);
  localparam logic [AW-1:0]     AUTO_LIM = AW'(AUTO_TO);
  localparam logic [ADDR_W-1:0] POST_LIM = ADDR_W'(POST_N);
  localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } state_t;

  state_t                     state, state_nxt;
  logic [7:0]                 dcnt;
  logic [ADDR_W-1:0]          ptr;
  logic [ADDR_W-1:0]          trig_addr;
  logic [ADDR_W-1:0]          post_cnt;
  logic [PW-1:0]              pre_cnt;
  logic [AW-1:0]              acnt;
  logic signed [SAMPLE_W-1:0] prev;
  logic                       prev_valid;

  logic capturing;
  logic post_full;
  logic sample_in;
  logic accept;
  logic rise;
  logic fall;
  logic trig_hit;
  logic auto_hit;
  logic enter_pre;
  logic enter_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    capturing  = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    post_full  = (state == POST) && (post_cnt == POST_LIM);
    sample_in  = capturing && cif.sample_valid;
    // Once the post-trigger quota is met, further strobes must not write.
    accept     = sample_in && (dcnt == 8'd0) && !post_full;
    rise       = ($signed(prev) < $signed(cif.trig_level)) &&
                 ($signed(cif.sample_data) >= $signed(cif.trig_level));
    fall       = ($signed(prev) >= $signed(cif.trig_level)) &&
                 ($signed(cif.sample_data) < $signed(cif.trig_level));
    trig_hit   = (state == WAIT_TRIG) && accept && prev_valid &&
                 (cif.trig_slope ? fall : rise);
    auto_hit   = (state == WAIT_TRIG) && accept && cif.auto_mode && (acnt == AUTO_LIM);

    case (state)
      IDLE:      if (cif.arm) state_nxt = PRE;
      PRE:       if (accept && (pre_cnt == PRE_LAST)) state_nxt = WAIT_TRIG;
      WAIT_TRIG: if (trig_hit || auto_hit) state_nxt = POST;
      POST:      if (post_full) state_nxt = DONE;
      DONE:      if (cif.rd_done) state_nxt = cif.cont ? PRE : IDLE;
      default:   state_nxt = IDLE;
    endcase

    if (cif.abort) state_nxt = IDLE;

    enter_pre  = (state_nxt == PRE) && (state != PRE);
    enter_done = (state_nxt == DONE) && (state != DONE);
  end

  assign cif.busy = capturing;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cif.wr_en       <= 1'b0;
      cif.wr_addr     <= '0;
      cif.wr_data     <= '0;
      cif.frame_start <= '0;
      cif.done        <= 1'b0;
      cif.forced      <= 1'b0;
      ptr             <= '0;
      trig_addr       <= '0;
      dcnt            <= '0;
      pre_cnt         <= '0;
      acnt            <= '0;
      post_cnt        <= '0;
      prev            <= '0;
      prev_valid      <= 1'b0;
    end else begin
      cif.wr_en <= accept && !cif.abort;
      cif.done  <= (state_nxt == DONE);

      if (accept) begin
        cif.wr_data <= cif.sample_data;
        cif.wr_addr <= ptr;
        ptr         <= ptr + ADDR_W'(1);
        prev        <= cif.sample_data;
        prev_valid  <= 1'b1;
      end

      // Reload-on-accept: a new decim value only bites at the next accepted sample.
      if (sample_in) begin
        dcnt <= (dcnt == 8'd0) ? cif.decim : (dcnt - 8'd1);
      end

      if ((state == PRE) && accept) pre_cnt <= pre_cnt + PW'(1);

      if ((state == WAIT_TRIG) && accept && (acnt != AUTO_LIM)) acnt <= acnt + AW'(1);

      if (trig_hit || auto_hit) begin
        trig_addr  <= ptr;
        cif.forced <= !trig_hit;
      end

      if ((state == POST) && accept) post_cnt <= post_cnt + ADDR_W'(1);

      if (enter_done) cif.frame_start <= trig_addr - PRE_OFS;

      if (enter_pre) begin
        ptr        <= '0;
        dcnt       <= '0;
        pre_cnt    <= '0;
        acnt       <= '0;
        post_cnt   <= '0;
        prev_valid <= 1'b0;
        cif.forced <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: expected RAM writes queued at stimulus time, popped by a write monitor.
module tb_capture_ctrl;
  localparam int SW = 14;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  capture_if #(.SAMPLE_W(SW), .ADDR_W(AW)) cif ();

  capture_ctrl #(
    .SAMPLE_W (SW),
    .ADDR_W   (AW),
    .PRE_DEPTH(256),
    .AUTO_TO  (2048)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cif(cif)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  bptr     = 0;
  int  sine_tbl[16] = '{0, 1531, 2828, 3695, 4000, 3695, 2828, 1531,
                        0, -1531, -2828, -3695, -4000, -3695, -2828, -1531};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Write monitor: every wr_en must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst && cif.wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: wr_en=1 addr %0d data %0d, required no write at %0t",
                 cif.wr_addr, cif.wr_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {22'b0, cif.wr_addr}, {22'b0, e.addr});
        check("wr_data", {18'b0, cif.wr_data}, {18'b0, e.data});
      end
    end
  end

  task automatic drive(input int val, input bit exp_wr);
    wr_t e;
    cif.sample_valid = 1'b1;
    cif.sample_data  = SW'(val);
    if (exp_wr) begin
      e.addr = AW'(bptr);
      e.data = SW'(val);
      exp_q.push_back(e);
      bptr = (bptr + 1) % 1024;
    end
    @(posedge clk);
    #1;
    cif.sample_valid = 1'b0;
  endtask

  task automatic do_arm();
    cif.arm = 1'b1;
    @(posedge clk);
    #1;
    cif.arm = 1'b0;
    bptr = 0;
  endtask

  task automatic pulse_rd();
    cif.rd_done = 1'b1;
    @(posedge clk);
    #1;
    cif.rd_done = 1'b0;
  endtask

  task automatic pulse_abort();
    cif.abort = 1'b1;
    @(posedge clk);
    #1;
    cif.abort = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!cif.done && i < 50) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(name, {31'b0, cif.done}, 1);
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Frame with a level crossing on the last PRE sample that must be ignored,
  // then a real rising crossing on the second WAIT_TRIG sample (address 257).
  task automatic edge_frame(input int post_n);
    for (int i = 0; i < 255; i++) drive(0, 1'b1);
    drive(200, 1'b1);
    drive(0, 1'b1);
    drive(200, 1'b1);
    for (int i = 0; i < post_n; i++) drive(7, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.sample_valid = 1'b0;
    cif.sample_data  = '0;
    cif.arm          = 1'b0;
    cif.abort        = 1'b0;
    cif.cont         = 1'b0;
    cif.auto_mode    = 1'b0;
    cif.trig_slope   = 1'b0;
    cif.trig_level   = SW'(100);
    cif.decim        = 8'd0;
    cif.rd_done      = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_wr_en", {31'b0, cif.wr_en}, 0);
    check("rst_wr_addr", {22'b0, cif.wr_addr}, 0);
    check("rst_wr_data", {18'b0, cif.wr_data}, 0);
    check("rst_frame_start", {22'b0, cif.frame_start}, 0);
    check("rst_done", {31'b0, cif.done}, 0);
    check("rst_forced", {31'b0, cif.forced}, 0);
    check("rst_busy", {31'b0, cif.busy}, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // 1: rising through 100, trigger sample at address 556
    do_arm();
    check("t1_busy_pre", {31'b0, cif.busy}, 1);
    for (int k = 0; k < 256; k++) drive(k, 1'b1);
    for (int j = 0; j < 300; j++) drive(-200 + j, 1'b1);
    drive(100, 1'b1);
    for (int j = 1; j <= 767; j++) drive(100 + j, 1'b1);
    wait_done("t1_done");
    check("t1_frame_start", {22'b0, cif.frame_start}, 300);
    check("t1_forced", {31'b0, cif.forced}, 0);
    check("t1_busy_done", {31'b0, cif.busy}, 0);
    check_drained("t1_writes_left");
    for (int j = 0; j < 3; j++) drive(5, 1'b0);
    pulse_rd();
    check("t1_idle_busy", {31'b0, cif.busy}, 0);
    check("t1_idle_done", {31'b0, cif.done}, 0);

    // 2: falling through 0, decim=3, trigger at accepted index 259
    cif.trig_slope = 1'b1;
    cif.trig_level = SW'(0);
    cif.decim      = 8'd3;
    do_arm();
    for (int k = 0; k <= 4104; k++) drive(sine_tbl[k % 16], (k % 4) == 0);
    wait_done("t2_done");
    check("t2_frame_start", {22'b0, cif.frame_start}, 3);
    check("t2_forced", {31'b0, cif.forced}, 0);
    check_drained("t2_writes_left");
    pulse_rd();

    // 3: auto trigger on the 2049th WAIT_TRIG sample, address 2304 mod 1024
    cif.trig_slope = 1'b0;
    cif.trig_level = SW'(1000);
    cif.decim      = 8'd0;
    cif.auto_mode  = 1'b1;
    do_arm();
    for (int k = 0; k < 3072; k++) drive(50, 1'b1);
    wait_done("t3_done");
    check("t3_forced", {31'b0, cif.forced}, 1);
    check("t3_frame_start", {22'b0, cif.frame_start}, 0);
    check_drained("t3_writes_left");
    pulse_rd();

    // 4: no trigger, stray arm/rd_done ignored, abort kills the in-flight write
    cif.auto_mode = 1'b0;
    do_arm();
    for (int k = 0; k < 1200; k++) drive(-5, 1'b1);
    cif.arm = 1'b1;
    drive(-5, 1'b1);
    cif.arm = 1'b0;
    cif.rd_done = 1'b1;
    drive(-5, 1'b1);
    cif.rd_done = 1'b0;
    for (int k = 0; k < 1200; k++) drive(-5, 1'b1);
    check("t4_busy_wait", {31'b0, cif.busy}, 1);
    check("t4_done_wait", {31'b0, cif.done}, 0);
    cif.sample_valid = 1'b1;
    cif.sample_data  = SW'(-5);
    cif.abort        = 1'b1;
    @(posedge clk);
    #1;
    cif.sample_valid = 1'b0;
    cif.abort        = 1'b0;
    check("t4_abort_busy", {31'b0, cif.busy}, 0);
    check("t4_abort_wr_en", {31'b0, cif.wr_en}, 0);
    cif.arm   = 1'b1;
    cif.abort = 1'b1;
    @(posedge clk);
    #1;
    cif.arm   = 1'b0;
    cif.abort = 1'b0;
    check("t4_arm_abort_busy", {31'b0, cif.busy}, 0);
    for (int k = 0; k < 3; k++) drive(-5, 1'b0);
    check_drained("t4_writes_left");

    // 5: continuous mode re-arms from address 0; PRE-final crossing ignored
    cif.trig_level = SW'(100);
    cif.cont       = 1'b1;
    do_arm();
    edge_frame(767);
    wait_done("t5_done1");
    check("t5_frame_start1", {22'b0, cif.frame_start}, 1);
    check_drained("t5_writes_left1");
    pulse_rd();
    bptr = 0;
    check("t5_rearm_done", {31'b0, cif.done}, 0);
    check("t5_rearm_busy", {31'b0, cif.busy}, 1);
    edge_frame(767);
    wait_done("t5_done2");
    check("t5_frame_start2", {22'b0, cif.frame_start}, 1);
    check_drained("t5_writes_left2");
    cif.cont = 1'b0;
    pulse_rd();
    check("t5_idle_busy", {31'b0, cif.busy}, 0);
    check("t5_idle_done", {31'b0, cif.done}, 0);
    for (int k = 0; k < 3; k++) drive(9, 1'b0);
    check_drained("t5_writes_left3");

    // 6: asynchronous reset during POST, then a clean capture from address 0
    do_arm();
    edge_frame(100);
    check("t6_wr_en_before", {31'b0, cif.wr_en}, 1);
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst_wr_en", {31'b0, cif.wr_en}, 0);
    check("t6_rst_done", {31'b0, cif.done}, 0);
    check("t6_rst_busy", {31'b0, cif.busy}, 0);
    check("t6_rst_wr_addr", {22'b0, cif.wr_addr}, 0);
    check("t6_rst_frame_start", {22'b0, cif.frame_start}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    do_arm();
    for (int k = 0; k < 10; k++) drive(k * 3, 1'b1);
    pulse_abort();
    check_drained("t6_writes_left");
    check("t6_final_busy", {31'b0, cif.busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
